// File: rtl/lcd_id_ctrl.sv
// lcd_id_ctrl: reads the panel ID straps {M2,M1,M0} from the shared RGB pads,
//   debounces them, and decodes the panel ID and pixel clock divide code.
// Latency: first sample SETTLE_CYC cycles after entering SETTLE, then one sample
//   every SAMPLE_GAP cycles; outputs load on the edge after the deciding sample.
// Backpressure: none. A rescan pulse restarts the scan from any state.
//
// Ports:
//   clk_50m     50 MHz system clock
//   rst_n       asynchronous active-low reset
//   rescan      single-cycle request to re-read the panel ID
//   lcd_rgb_in  RGB pad inputs; straps M2/M1/M0 on bits 7/15/23
//   rgb_oe      RGB pad output enable, low while the straps are being read
//   id_valid    lcd_id, div_sel and pix_en are valid
//   id_err      straps never stabilised, so the default ID is in use
//   lcd_id      decoded panel ID
//   div_sel     pixel divide code: 0=/1, 1=/2, 2=/4, 3=/6
//   pix_en      pixel-rate clock enable in the clk_50m domain
module lcd_id_ctrl #(
  parameter int SETTLE_CYC  = 1000,
  parameter int SAMPLE_GAP  = 250,
  parameter int MATCH_CNT   = 3,
  parameter int MAX_SAMPLES = 16
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        rescan,
  input  logic [23:0] lcd_rgb_in,
  output logic        rgb_oe,
  output logic        id_valid,
  output logic        id_err,
  output logic [15:0] lcd_id,
  output logic [1:0]  div_sel,
  output logic        pix_en
);

  // One timer serves both the settle wait and the inter-sample gap, so it is
  // sized for the larger of the two.
  localparam int TMR_MAX = (SETTLE_CYC > SAMPLE_GAP) ? SETTLE_CYC : SAMPLE_GAP;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
  localparam int MW      = $clog2(MATCH_CNT + 1);
  localparam int SW      = $clog2(MAX_SAMPLES + 1);

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(SAMPLE_GAP - 1);
  localparam logic [MW-1:0] MATCH_DONE  = MW'(MATCH_CNT);
  localparam logic [SW-1:0] SAMP_DONE   = SW'(MAX_SAMPLES);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [15:0] DEFAULT_ID  = 16'h4342;
  localparam logic [1:0]  DEFAULT_DIV = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] tmr;
  logic [MW-1:0] match;
  logic [SW-1:0] nsamp;
  logic [2:0]    last_strap;
  logic [2:0]    div_cnt;

  logic [2:0]    strap;
  logic          hit;
  logic          exhausted;
  logic [17:0]   dec;
  logic [2:0]    div_last;
  logic [2:0]    div_nxt;

  assign strap     = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};
  assign hit       = (match == MATCH_DONE);
  assign exhausted = (nsamp == SAMP_DONE);

  // Decode of the last accepted strap value: {lcd_id, div_sel}.
  always_comb begin
    dec = {DEFAULT_ID, DEFAULT_DIV};
    case (last_strap)
      3'b000:  dec = {16'h4342, 2'd3};
      3'b001:  dec = {16'h7084, 2'd1};
      3'b010:  dec = {16'h7016, 2'd0};
      3'b100:  dec = {16'h1018, 2'd0};
      3'b101:  dec = {16'h1963, 2'd0};
      default: dec = {DEFAULT_ID, DEFAULT_DIV};
    endcase
  end

  // Terminal count of the pixel divider (N-1) for the active divide code.
  always_comb begin
    div_last = 3'd0;
    case (div_sel)
      2'd1:    div_last = 3'd1;
      2'd2:    div_last = 3'd3;
      2'd3:    div_last = 3'd5;
      default: div_last = 3'd0;
    endcase
  end

  assign div_nxt = (div_cnt == div_last) ? 3'd0 : div_cnt + 3'd1;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SETTLE;
      tmr        <= '0;
      match      <= '0;
      nsamp      <= '0;
      last_strap <= '0;
      div_cnt    <= '0;
      rgb_oe     <= 1'b0;
      id_valid   <= 1'b0;
      id_err     <= 1'b0;
      pix_en     <= 1'b0;
      lcd_id     <= 16'h0000;
      div_sel    <= DEFAULT_DIV;
    end else if (rescan) begin
      // lcd_id/div_sel deliberately retained until the next load in DONE.
      state      <= ST_SETTLE;
      tmr        <= '0;
      match      <= '0;
      nsamp      <= '0;
      last_strap <= '0;
      div_cnt    <= '0;
      rgb_oe     <= 1'b0;
      id_valid   <= 1'b0;
      pix_en     <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (tmr == SETTLE_LAST) begin
            tmr        <= '0;
            state      <= ST_SAMPLE;
            last_strap <= strap;
            nsamp      <= SW'(1);
            match      <= MW'(1);
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_SAMPLE: begin
          // A match on the final budgeted sample still counts as a match.
          if (hit) begin
            state    <= ST_DONE;
            lcd_id   <= dec[17:2];
            div_sel  <= dec[1:0];
            id_err   <= 1'b0;
            id_valid <= 1'b1;
            rgb_oe   <= 1'b1;
            div_cnt  <= '0;
            pix_en   <= (dec[1:0] == 2'd0);
          end else if (exhausted) begin
            state    <= ST_DONE;
            lcd_id   <= DEFAULT_ID;
            div_sel  <= DEFAULT_DIV;
            id_err   <= 1'b1;
            id_valid <= 1'b1;
            rgb_oe   <= 1'b1;
            div_cnt  <= '0;
            pix_en   <= 1'b0;
          end else if (tmr == GAP_LAST) begin
            tmr        <= '0;
            last_strap <= strap;
            nsamp      <= nsamp + SW'(1);
            match      <= (strap == last_strap) ? match + MW'(1) : MW'(1);
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_DONE: begin
          // Divider count is 0 in the first valid cycle; pix_en marks count N-1.
          if (div_sel == 2'd0) begin
            pix_en <= 1'b1;
          end else begin
            div_cnt <= div_nxt;
            pix_en  <= (div_nxt == div_last);
          end
        end
        default: begin
          state <= ST_SETTLE;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_id_ctrl.sv
module tb_lcd_id_ctrl;

  localparam int SC  = 10;
  localparam int GAP = 4;
  localparam int MC  = 3;
  localparam int MS  = 16;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        rescan;
  logic [23:0] lcd_rgb_in;
  logic        rgb_oe;
  logic        id_valid;
  logic        id_err;
  logic [15:0] lcd_id;
  logic [1:0]  div_sel;
  logic        pix_en;

  lcd_id_ctrl #(
    .SETTLE_CYC (SC),
    .SAMPLE_GAP (GAP),
    .MATCH_CNT  (MC),
    .MAX_SAMPLES(MS)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rescan    (rescan),
    .lcd_rgb_in(lcd_rgb_in),
    .rgb_oe    (rgb_oe),
    .id_valid  (id_valid),
    .id_err    (id_err),
    .lcd_id    (lcd_id),
    .div_sel   (div_sel),
    .pix_en    (pix_en)
  );

  always #10 clk_50m = ~clk_50m;

  int n_assert = 0;
  int n_fail   = 0;

  // Strap value presented at each of the (up to) MS sample points.
  logic [2:0]  seq [MS];
  logic [15:0] prev_id;
  logic [1:0]  prev_div;

  // Panel table from the datasheet view: strap code -> ID / divide code.
  logic [15:0] id_tab  [8];
  logic [1:0]  div_tab [8];
  int          div_n   [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rgb_oe",  32'(rgb_oe),   32'd0);
    chk("rst_valid",   32'(id_valid), 32'd0);
    chk("rst_err",     32'(id_err),   32'd0);
    chk("rst_pix",     32'(pix_en),   32'd0);
    chk("rst_lcd_id",  32'(lcd_id),   32'h0000);
    chk("rst_div_sel", 32'(div_sel),  32'd3);
  endtask

  // Reference: walk the sample sequence, find the first run of MC identical
  // samples; the outputs appear one edge after that sample.
  task automatic model(output int done_cyc, output logic [15:0] eid,
                       output logic [1:0] ediv, output logic eerr);
    int run;
    run = 0;
    for (int i = 0; i < MS; i++) begin
      run = (i > 0 && seq[i] == seq[i-1]) ? run + 1 : 1;
      if (run == MC) begin
        done_cyc = SC + GAP * i + 1;
        eid      = id_tab[seq[i]];
        ediv     = div_tab[seq[i]];
        eerr     = 1'b0;
        return;
      end
    end
    done_cyc = SC + GAP * (MS - 1) + 1;
    eid      = 16'h4342;
    ediv     = 2'd3;
    eerr     = 1'b1;
  endtask

  // Drive pads for edge number e: the intended strap at sample edges,
  // random junk on the strap bits otherwise, random data on every other bit.
  task automatic drive(input int e);
    logic [23:0] v;
    logic [2:0]  s;
    v = 24'($urandom);
    if (e >= SC && (e - SC) % GAP == 0 && (e - SC) / GAP < MS)
      s = seq[(e - SC) / GAP];
    else
      s = 3'($urandom);
    v[7]  = s[2];
    v[15] = s[1];
    v[23] = s[0];
    lcd_rgb_in = v;
  endtask

  // Called at a falling edge with the DUT just (re)started in SETTLE count 0.
  task automatic run_scan(input string tag, input int ncyc);
    int          done_cyc;
    logic [15:0] eid;
    logic [1:0]  ediv;
    logic        eerr;
    logic        v;
    logic        ep;
    int          n;
    model(done_cyc, eid, ediv, eerr);
    n = div_n[ediv];
    for (int c = 0; c < ncyc; c++) begin
      v = (c >= done_cyc);
      chk({tag, "_valid"}, 32'(id_valid), 32'(v));
      chk({tag, "_rgb_oe"}, 32'(rgb_oe), 32'(v));
      if (v) begin
        ep = (n == 1) || (((c - done_cyc) % n) == n - 1);
        chk({tag, "_lcd_id"}, 32'(lcd_id), 32'(eid));
        chk({tag, "_div_sel"}, 32'(div_sel), 32'(ediv));
        chk({tag, "_err"}, 32'(id_err), 32'(eerr));
      end else begin
        ep = 1'b0;
        chk({tag, "_hold_id"}, 32'(lcd_id), 32'(prev_id));
        chk({tag, "_hold_div"}, 32'(div_sel), 32'(prev_div));
      end
      chk({tag, "_pix_en"}, 32'(pix_en), 32'(ep));
      drive(c + 1);
      @(posedge clk_50m);
      @(negedge clk_50m);
    end
    if (done_cyc < ncyc) begin
      prev_id  = eid;
      prev_div = ediv;
    end
  endtask

  task automatic do_rescan();
    rescan = 1'b1;
    lcd_rgb_in = 24'($urandom);
    @(posedge clk_50m);
    @(negedge clk_50m);
    rescan = 1'b0;
  endtask

  task automatic fill(input logic [2:0] s);
    for (int i = 0; i < MS; i++) seq[i] = s;
  endtask

  initial begin
    id_tab  = '{16'h4342, 16'h7084, 16'h7016, 16'h4342, 16'h1018, 16'h1963, 16'h4342, 16'h4342};
    div_tab = '{2'd3, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3};
    div_n   = '{1, 2, 4, 6};

    rst_n      = 1'b0;
    rescan     = 1'b0;
    lcd_rgb_in = '0;
    prev_id    = 16'h0000;
    prev_div   = 2'd3;
    repeat (3) @(negedge clk_50m);
    chk_reset_vals();

    // Straps 001 stable from reset release.
    fill(3'b001);
    rst_n = 1'b1;
    run_scan("s001", 30);

    // Rescan with straps changed to 100.
    fill(3'b100);
    do_rescan();
    run_scan("rescan100", 30);

    // Reset back, straps 000 -> /6 divider.
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    prev_id  = 16'h0000;
    prev_div = 2'd3;
    @(negedge clk_50m);
    fill(3'b000);
    rst_n = 1'b1;
    run_scan("s000", 40);

    // Straps alternate every sample -> budget exhausted.
    for (int i = 0; i < MS; i++) seq[i] = (i % 2 == 0) ? 3'b010 : 3'b100;
    do_rescan();
    run_scan("toggle", 80);

    // 101 with the second sample glitched to 111.
    fill(3'b101);
    seq[1] = 3'b111;
    do_rescan();
    run_scan("glitch", 40);

    // Reset mid-scan, then a full scan with an unlisted code.
    fill(3'b001);
    do_rescan();
    run_scan("pre_rst", 12);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    prev_id  = 16'h0000;
    prev_div = 2'd3;
    @(negedge clk_50m);
    fill(3'b011);
    rst_n = 1'b1;
    run_scan("post_rst", 40);

    // Random strap sequences with occasional glitches.
    for (int r = 0; r < 6; r++) begin
      logic [2:0] base;
      base = 3'($urandom_range(0, 7));
      for (int i = 0; i < MS; i++)
        seq[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : base;
      do_rescan();
      run_scan("rand", 80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
